// File: rtl/btn_sched_pkg.sv
// Shared types and helpers for the scheduled button debouncer.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, reference DELAY values for hardware and
// simulation builds, and the round-robin modulo-increment helper.
package btn_sched_pkg;

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    WAIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int DELAY_HW  = 1000000;
  localparam int DELAY_SIM = 10;

  // Next round-robin position after idx, wrapping at n.
  function automatic int next_rr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// N-bit two-flop synchronizer for asynchronous board inputs.
// Latency: 2 cycles from input change to o_sync.
// Backpressure: none; samples every cycle.
//
// Ports:
//   i_clk   system clock, rising edge
//   i_rst   asynchronous active-high reset; flops reset to all 1 (released)
//   i_async raw asynchronous inputs
//   o_sync  synchronized copy of i_async
module btn_sync #(
  parameter int N_BTN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_BTN-1:0] i_async,
  output logic [N_BTN-1:0] o_sync
);

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  // Reset to all 1 so active-low buttons read as released out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
    end
  end

  assign o_sync = r_sync2;

endmodule

// File: rtl/btn_debounce_sched.sv
// Debounces N_BTN active-low buttons with one shared, round-robin scheduled counter.
// Latency: 2 (sync) + DELAY+2 (scan, qualify, commit) cycles from raw change to o_btn_stable.
// Backpressure: none; non-granted buttons are ignored while busy and re-examined on the next scan.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_btn_raw      raw buttons, active-low, asynchronous to i_clk
//   o_btn_stable   debounced level, 1 = pressed
//   o_btn_press    one-cycle pulse when a button commits to pressed
//   o_btn_release  one-cycle pulse when a button commits to released
//   o_busy         counter granted (WAIT or COMMIT)
//   o_grant_idx    button currently owning the counter; holds last value when idle
//
// DELAY-1 must fit in CNT_W bits; N_BTN is expected in 2..8.
module btn_debounce_sched
  import btn_sched_pkg::*;
#(
  parameter int N_BTN = 4,
  parameter int DELAY = DELAY_HW,
  parameter int CNT_W = 20
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_BTN-1:0]         i_btn_raw,
  output logic [N_BTN-1:0]         o_btn_stable,
  output logic [N_BTN-1:0]         o_btn_press,
  output logic [N_BTN-1:0]         o_btn_release,
  output logic                     o_busy,
  output logic [$clog2(N_BTN)-1:0] o_grant_idx
);

  localparam int IDX_W = $clog2(N_BTN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

  logic [N_BTN-1:0] w_sync;
  logic [N_BTN-1:0] w_lvl;
  logic [N_BTN-1:0] w_mis;
  logic             w_found;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_next_rr;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_target;
  logic             r_busy;
  logic [N_BTN-1:0] r_stable;
  logic [N_BTN-1:0] r_press;
  logic [N_BTN-1:0] r_release;

  btn_sync #(
    .N_BTN (N_BTN)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_btn_raw),
    .o_sync  (w_sync)
  );

  // Pressed = 1 after inversion; a mismatch is a candidate level change.
  assign w_lvl = ~w_sync;
  assign w_mis = w_lvl ^ r_stable;

  // First mismatching button at or after r_rr_ptr, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < N_BTN; k++) begin
      int j;
      j = int'(r_rr_ptr) + k;
      if (j >= N_BTN) j = j - N_BTN;
      if (!w_found && w_mis[j]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(j);
      end
    end
  end

  // The served button drops to lowest priority after commit or abort.
  assign w_next_rr = IDX_W'(next_rr(int'(r_grant_idx), N_BTN));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= SCAN;
      r_cnt       <= '0;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_target    <= 1'b0;
      r_busy      <= 1'b0;
      r_stable    <= '0;
      r_press     <= '0;
      r_release   <= '0;
    end else begin
      // Pulses live for one cycle unless COMMIT sets a bit below.
      r_press   <= '0;
      r_release <= '0;
      case (r_state)
        SCAN: begin
          if (w_found) begin
            r_grant_idx <= w_sel;
            r_cnt       <= '0;
            r_target    <= w_lvl[w_sel];
            r_busy      <= 1'b1;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (w_lvl[r_grant_idx] != r_target) begin
            // Bounced back before qualifying: discard, keep the old level.
            r_cnt    <= '0;
            r_rr_ptr <= w_next_rr;
            r_busy   <= 1'b0;
            r_state  <= SCAN;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= COMMIT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        COMMIT: begin
          r_stable[r_grant_idx]  <= r_target;
          r_press[r_grant_idx]   <= r_target;
          r_release[r_grant_idx] <= ~r_target;
          r_rr_ptr               <= w_next_rr;
          r_cnt                  <= '0;
          r_busy                 <= 1'b0;
          r_state                <= SCAN;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= SCAN;
        end
      endcase
    end
  end

  assign o_btn_stable  = r_stable;
  assign o_btn_press   = r_press;
  assign o_btn_release = r_release;
  assign o_busy        = r_busy;
  assign o_grant_idx   = r_grant_idx;

endmodule

// File: tb/tb_btn_debounce_sched.sv
module tb_btn_debounce_sched;

  localparam int N = 4;
  localparam int D = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw = '1;
  logic [N-1:0] btn_stable, btn_press, btn_release;
  logic         busy;
  logic [1:0]   grant_idx;

  always #5 clk = ~clk;

  btn_debounce_sched #(
    .N_BTN (N),
    .DELAY (D),
    .CNT_W (4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_btn_raw     (btn_raw),
    .o_btn_stable  (btn_stable),
    .o_btn_press   (btn_press),
    .o_btn_release (btn_release),
    .o_busy        (busy),
    .o_grant_idx   (grant_idx)
  );

  typedef struct {
    int           edge_n;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] stable;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a button is granted when idle and mismatched (round
  // robin), must hold its new synchronized level for D cycles after the
  // grant, and its commit is visible D+1 cycles after the grant.
  logic [N-1:0] hist[$];
  int           ecnt;
  bit           m_busy;
  int           m_idx, m_rr, m_gedge;
  logic         m_tgt;
  logic [N-1:0] m_stable;

  task automatic model_reset();
    hist.delete();
    hist.push_back('1);
    hist.push_back('1);
    ecnt     = 0;
    m_busy   = 0;
    m_idx    = 0;
    m_rr     = 0;
    m_stable = '0;
    expq.delete();
  endtask

  task automatic model_step(input logic [N-1:0] raw);
    logic [N-1:0] lv;
    bit           found;
    int           age;
    exp_t         e;
    ecnt++;
    hist.push_back(raw);
    lv = ~hist[ecnt-1];   // raw seen two edges earlier
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (!found && lv[j] != m_stable[j]) begin
          found   = 1;
          m_busy  = 1;
          m_idx   = j;
          m_tgt   = lv[j];
          m_gedge = ecnt;
        end
      end
    end else begin
      age = ecnt - m_gedge;
      if (age <= D) begin
        if (lv[m_idx] != m_tgt) begin
          m_busy = 0;
          m_rr   = (m_idx + 1) % N;
        end
      end else begin
        m_stable[m_idx] = m_tgt;
        e.edge_n = ecnt;
        e.press  = '0;
        e.rel    = '0;
        if (m_tgt) e.press[m_idx] = 1'b1;
        else       e.rel[m_idx]   = 1'b1;
        e.stable = m_stable;
        expq.push_back(e);
        m_rr   = (m_idx + 1) % N;
        m_busy = 0;
      end
    end
  endtask

  // Monitor: compares every cycle and pops expected pulses as they appear.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [N-1:0] pl;
      exp_t         e;
      pl = btn_press | btn_release;
      chk("pulse_onehot", ($countones(pl) <= 1), 1);
      chk("busy", busy, m_busy);
      chk("stable", btn_stable, m_stable);
      if (m_busy) chk("grant_idx", grant_idx, m_idx);
      while (expq.size() > 0 && expq[0].edge_n < ecnt) begin
        checks++;
        errors++;
        $display("FAIL missed_pulse: expected press %b release %b at edge %0d, no pulse observed",
                 expq[0].press, expq[0].rel, expq[0].edge_n);
        void'(expq.pop_front());
      end
      if (pl != '0) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got press %b release %b, expected none",
                   btn_press, btn_release);
        end else begin
          e = expq.pop_front();
          chk("pulse_edge", ecnt, e.edge_n);
          chk("pulse_press", btn_press, e.press);
          chk("pulse_release", btn_release, e.rel);
          chk("pulse_stable", btn_stable, e.stable);
        end
      end
    end
  end

  task automatic tick(input logic [N-1:0] raw);
    @(negedge clk);
    btn_raw = raw;
    @(posedge clk);
    model_step(raw);
    #1;
  endtask

  task automatic chk_cleared(input string name);
    chk({name, "_stable"}, btn_stable, 0);
    chk({name, "_press"}, btn_press, 0);
    chk({name, "_release"}, btn_release, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_grant"}, grant_idx, 0);
  endtask

  task automatic do_reset();
    mon_en = 0;
    @(negedge clk);
    btn_raw = '1;
    rst = 1'b1;
    #1;
    chk_cleared("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mon_en = 1;
  endtask

  int order[$];

  initial begin
    model_reset();

    // Idle after reset.
    do_reset();
    repeat (50) tick('1);
    chk_cleared("idle50");

    // Single press / release of button 1.
    for (int k = 1; k <= 14; k++) begin
      tick(4'b1101);
      if (k == 2)  chk("b1_busy_early", busy, 0);
      if (k == 3)  chk("b1_busy_rise", busy, 1);
      if (k == 3)  chk("b1_grant", grant_idx, 1);
      if (k == 13) chk("b1_stable_pre", btn_stable, 4'b0000);
      if (k == 14) chk("b1_stable", btn_stable, 4'b0010);
      if (k == 14) chk("b1_press", btn_press, 4'b0010);
    end
    tick(4'b1101);
    chk("b1_press_one_cycle", btn_press, 4'b0000);
    repeat (5) tick(4'b1101);
    for (int k = 1; k <= 14; k++) begin
      tick(4'b1111);
      if (k == 13) chk("b1_release_pre", btn_release, 4'b0000);
      if (k == 14) chk("b1_release", btn_release, 4'b0010);
      if (k == 14) chk("b1_stable_rel", btn_stable, 4'b0000);
    end
    repeat (5) tick('1);

    // Bounce on button 2: first attempt aborts, second commits.
    repeat (5) tick(4'b1011);
    repeat (3) tick(4'b1111);
    chk("b2_no_commit_on_bounce", btn_stable, 4'b0000);
    for (int k = 1; k <= 14; k++) begin
      tick(4'b1011);
      if (k == 13) chk("b2_stable_pre", btn_stable, 4'b0000);
      if (k == 14) chk("b2_stable", btn_stable, 4'b0100);
      if (k == 14) chk("b2_press", btn_press, 4'b0100);
    end
    repeat (5) tick(4'b1011);

    // Buttons 0 and 3 together: 0 first, 3 twelve cycles later.
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      tick(4'b0110);
      if (k == 14) chk("b03_first", btn_stable, 4'b0001);
      if (k == 25) chk("b03_second_pre", btn_stable, 4'b0001);
      if (k == 26) chk("b03_second", btn_stable, 4'b1001);
      if (k == 26) chk("b03_press3", btn_press, 4'b1000);
    end

    // Leave rr pointer at 2, then press everything: order 2,3,0,1.
    do_reset();
    repeat (16) tick(4'b1101);
    repeat (16) tick(4'b1111);
    order.delete();
    for (int k = 0; k < 60; k++) begin
      tick(4'b0000);
      for (int b = 0; b < N; b++) if (btn_press[b]) order.push_back(b);
    end
    chk("rr_count", order.size(), 4);
    if (order.size() == 4) begin
      chk("rr_order0", order[0], 2);
      chk("rr_order1", order[1], 3);
      chk("rr_order2", order[2], 0);
      chk("rr_order3", order[3], 1);
    end

    // Reset in the middle of a qualification.
    do_reset();
    repeat (14) tick(4'b0111);
    chk("mid_pre_stable", btn_stable, 4'b1000);
    repeat (9) tick(4'b0110);    // button 0 granted, count at 6
    chk("mid_busy", busy, 1);
    mon_en = 0;
    rst = 1'b1;
    #1;
    chk_cleared("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mon_en = 1;
    for (int k = 1; k <= 30; k++) begin
      tick(4'b0110);
      if (k == 13) chk("mid_restart_pre", btn_stable, 4'b0000);
      if (k == 14) chk("mid_restart", btn_stable, 4'b0001);
    end

    // Randomized bouncing on all buttons against the model.
    do_reset();
    begin
      logic [N-1:0] r;
      r = '1;
      for (int c = 0; c < 3000; c++) begin
        for (int b = 0; b < N; b++)
          if ($urandom_range(0, 15) == 0) r[b] = ~r[b];
        tick(r);
      end
      repeat (200) tick(r);
    end
    chk("queue_drained", expq.size(), 0);

    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
